// File: rtl/hdmi_out_timing_gen_pkg.sv
// Shared types and constants for the HDMI-out video timing path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, RGB width, colour-bar table, 720p timing defaults.
package hdmi_out_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    // 1280x720p60 raster.
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    // Colour bars, left to right. Index 0 is the leftmost (white) bar.
    localparam logic [7:0][RGB_W-1:0] BAR_RGB = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

endpackage

// File: rtl/hdmi_out_timing_gen_if.sv
// Bundle between the prefetch FIFO / control plane and the timing generator.
// Latency: n/a (wires only).
// Backpressure: none; the FIFO side is a rd_en/rd_vld pop handshake.
//
// master = timing generator, slave = FIFO + control + encoder side.
// With TEST_PATTERN_EN defined the pattern_sel signal is added.
interface hdmi_out_timing_gen_if;
    import hdmi_out_pkg::*;

    logic             en;
    logic             fifo_rd_vld;
    logic [RGB_W-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             vid_hs;
    logic             vid_vs;
    logic             vid_de;
    logic [RGB_W-1:0] vid_rgb;
    logic             frame_req;
    logic             underflow;
    logic             underflow_clr;
    logic [15:0]      underflow_cnt;
`ifdef TEST_PATTERN_EN
    logic             pattern_sel;
`endif

    modport master (
        input  en, fifo_rd_vld, fifo_rd_data, underflow_clr,
`ifdef TEST_PATTERN_EN
        input  pattern_sel,
`endif
        output fifo_rd_en, vid_hs, vid_vs, vid_de, vid_rgb,
        output frame_req, underflow, underflow_cnt
    );

    modport slave (
        output en, fifo_rd_vld, fifo_rd_data, underflow_clr,
`ifdef TEST_PATTERN_EN
        output pattern_sel,
`endif
        input  fifo_rd_en, vid_hs, vid_vs, vid_de, vid_rgb,
        input  frame_req, underflow, underflow_cnt
    );

endinterface

// File: rtl/hdmi_out_timing_gen_raster_cnt.sv
// Free-running h/v raster counters with active, raw sync and vblank decode.
// Latency: decodes are combinational from the registered counters.
// Backpressure: none; counts every cycle inc is high, clr forces 0,0.
//
// Ports: clk, rst (async, active-high), clr, inc -> h_cnt, v_cnt, active,
// hs_raw, vs_raw (active-high, polarity applied by the user), vblank_start.
module video_raster_cnt
    import hdmi_out_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYN_S  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYN_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYN_S  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYN_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST_C);
    assign v_last = (v_cnt == V_LAST_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (inc) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_raw       = (h_cnt >= H_SYN_S) && (h_cnt < H_SYN_E);
    // v_cnt only moves on h wrap, so vs edges land at h=0.
    assign vs_raw       = (v_cnt >= V_SYN_S) && (v_cnt < V_SYN_E);
    assign vblank_start = (h_cnt == '0) && (v_cnt == V_ACT_C);

endmodule

// File: rtl/hdmi_out_timing_gen.sv
// HDMI-out raster timing generator: pops one FIFO word per active pixel.
// Latency: video outputs registered 1 cycle after the counter position.
// Backpressure: none; raster never stalls, an empty FIFO yields FILL_RGB.
//
// Ports: clk, rst (async, active-high); bus (master modport): en,
// fifo_rd_vld/fifo_rd_data/fifo_rd_en, vid_hs/vs/de/rgb, frame_req,
// underflow/underflow_clr/underflow_cnt. Optional macro TEST_PATTERN_EN
// adds pattern_sel and an 8-bar colour pattern that bypasses the FIFO.
module hdmi_out_timing_gen
    import hdmi_out_pkg::*;
#(
    parameter int               H_ACTIVE = H_ACTIVE_720P,
    parameter int               H_FP     = H_FP_720P,
    parameter int               H_SYNC   = H_SYNC_720P,
    parameter int               H_BP     = H_BP_720P,
    parameter int               V_ACTIVE = V_ACTIVE_720P,
    parameter int               V_FP     = V_FP_720P,
    parameter int               V_SYNC   = V_SYNC_720P,
    parameter int               V_BP     = V_BP_720P,
    parameter bit               HS_POL   = 1'b1,
    parameter bit               VS_POL   = 1'b1,
    parameter logic [RGB_W-1:0] FILL_RGB = 24'h000000,
    parameter int               CNT_W    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    hdmi_out_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    state_t           state;
    logic             stop_pend;
    logic             run;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic             vblank_start;
    logic             frame_last;
    logic             pat_now;
    logic             prime_go;
    logic             starved;
    logic [RGB_W-1:0] px_rgb;

    logic             de_q;
    logic             hs_q;
    logic             vs_q;
    logic [RGB_W-1:0] rgb_q;
    logic             frame_req_q;
    logic             uf_q;
    logic [15:0]      uf_cnt_q;

    assign run = (state == RUN);

    // Counters sit at 0,0 outside RUN so the first RUN cycle is pixel 0.
    video_raster_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CNT_W    (CNT_W)
    ) u_raster (
        .clk          (clk),
        .rst          (rst),
        .clr          (~run),
        .inc          (run),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .active       (active),
        .hs_raw       (hs_raw),
        .vs_raw       (vs_raw),
        .vblank_start (vblank_start)
    );

    assign frame_last = (h_cnt == H_LAST_C) && (v_cnt == V_LAST_C);

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic             pat_q;
    logic [CNT_W-1:0] bar_raw;
    logic [2:0]       bar_idx;

    // The frame's first pixel already uses the freshly sampled select.
    assign pat_now  = ((h_cnt == '0) && (v_cnt == '0)) ? bus.pattern_sel : pat_q;
    assign prime_go = bus.fifo_rd_vld | bus.pattern_sel;
    assign bar_raw  = h_cnt / CNT_W'(BAR_W);
    assign bar_idx  = (bar_raw > CNT_W'(7)) ? 3'd7 : bar_raw[2:0];
`else
    assign pat_now  = 1'b0;
    assign prime_go = bus.fifo_rd_vld;
`endif

    assign bus.fifo_rd_en = run & active & bus.fifo_rd_vld & ~pat_now;
    assign starved        = run & active & ~bus.fifo_rd_vld & ~pat_now;

    always_comb begin
        px_rgb = bus.fifo_rd_vld ? bus.fifo_rd_data : FILL_RGB;
`ifdef TEST_PATTERN_EN
        if (pat_now) px_rgb = BAR_RGB[bar_idx];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stop_pend   <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            rgb_q       <= '0;
            frame_req_q <= 1'b0;
            uf_q        <= 1'b0;
            uf_cnt_q    <= '0;
`ifdef TEST_PATTERN_EN
            pat_q       <= 1'b0;
`endif
        end else begin
            frame_req_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state       <= PRIME;
                        frame_req_q <= 1'b1;
                    end
                end
                PRIME: begin
                    if (!bus.en)       state <= IDLE;
                    else if (prime_go) state <= RUN;
                end
                RUN: begin
                    if (vblank_start) frame_req_q <= 1'b1;
                    // A drop of en anywhere in the frame is remembered; the
                    // frame always runs to its last pixel before stopping.
                    if (frame_last) begin
                        if (stop_pend || !bus.en) state <= IDLE;
                        stop_pend <= 1'b0;
                    end else if (!bus.en) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            de_q  <= run & active;
            hs_q  <= (run & hs_raw) ? HS_POL : ~HS_POL;
            vs_q  <= (run & vs_raw) ? VS_POL : ~VS_POL;
            rgb_q <= (run & active) ? px_rgb : '0;

            if (bus.underflow_clr) begin
                uf_q     <= 1'b0;
                uf_cnt_q <= '0;
            end else if (starved) begin
                uf_q <= 1'b1;
                if (uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
            end

`ifdef TEST_PATTERN_EN
            if (run && (h_cnt == '0) && (v_cnt == '0)) pat_q <= bus.pattern_sel;
`endif
        end
    end

    assign bus.vid_de        = de_q;
    assign bus.vid_hs        = hs_q;
    assign bus.vid_vs        = vs_q;
    assign bus.vid_rgb       = rgb_q;
    assign bus.frame_req     = frame_req_q;
    assign bus.underflow     = uf_q;
    assign bus.underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_hdmi_out_timing_gen.sv
// Self-checking bench for hdmi_out_timing_gen on a small 14x7 raster.
// Latency: expects video outputs one cycle after the modelled position.
// Backpressure: bench FIFO model drives rd_vld/rd_data and pops on rd_en.
module tb_hdmi_out_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;   // 14
    localparam int VT = VA + VF + VSW + VB;   // 7
    localparam logic [23:0] FILL = 24'hABCDEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdmi_out_timing_gen_if bus ();

    hdmi_out_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .HS_POL   (1'b1), .VS_POL (1'b1), .FILL_RGB (FILL), .CNT_W (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [23:0] fifo_q[$];
    logic [23:0] exp_q[$];
    bit          autofill  = 1'b0;
    logic [23:0] next_word = '0;
    int          st_v = -1, st_h = 0, st_len = 0;

    // Reference raster model: 0 idle, 1 prime, 2 run.
    int m_state = 0, mh = 0, mv = 0;
    bit m_stop = 1'b0;
    bit p_active = 1'b0, p_hs = 1'b0, p_vs = 1'b0, p_freq = 1'b0;
    bit e_uf = 1'b0;
    int e_cnt = 0;
    int pop_cnt = 0, freq_cnt = 0, hs_len = 0, vs_len = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "de"},        bus.vid_de,        0);
        chk({pfx, "hs"},        bus.vid_hs,        0);
        chk({pfx, "vs"},        bus.vid_vs,        0);
        chk({pfx, "rgb"},       bus.vid_rgb,       0);
        chk({pfx, "rd_en"},     bus.fifo_rd_en,    0);
        chk({pfx, "frame_req"}, bus.frame_req,     0);
        chk({pfx, "underflow"}, bus.underflow,     0);
        chk({pfx, "uf_cnt"},    bus.underflow_cnt, 0);
    endtask

    // One pixel clock: drive FIFO, check previous-cycle outputs, advance model.
    task automatic step();
        bit vld, active, starve, popped;
        starve = (m_state == 2) && (mv == st_v) && (mh >= st_h) && (mh < st_h + st_len);
        if (autofill && fifo_q.size() < 4) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
        vld = (fifo_q.size() != 0) && !starve;
        bus.fifo_rd_vld  = vld;
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 24'h0;
        active = (m_state == 2) && (mh < HA) && (mv < VA);

        @(negedge clk);
        chk("de",        bus.vid_de,        p_active);
        chk("hs",        bus.vid_hs,        p_hs);
        chk("vs",        bus.vid_vs,        p_vs);
        chk("frame_req", bus.frame_req,     p_freq);
        chk("underflow", bus.underflow,     e_uf);
        chk("uf_cnt",    bus.underflow_cnt, e_cnt);
        if (p_active) begin
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else                   chk("rgb", bus.vid_rgb, exp_q.pop_front());
        end else begin
            chk("rgb_blank", bus.vid_rgb, 0);
        end
        if (bus.vid_hs) hs_len++;
        else begin
            if (hs_len != 0) chk("hs_width", hs_len, HSW);
            hs_len = 0;
        end
        if (bus.vid_vs) vs_len++;
        else begin
            if (vs_len != 0) chk("vs_width", vs_len, VSW * HT);
            vs_len = 0;
        end
        if (bus.frame_req) freq_cnt++;
        if (active) exp_q.push_back(vld ? fifo_q[0] : FILL);
        chk("rd_en", bus.fifo_rd_en, active && vld);
        popped = bus.fifo_rd_en;

        p_active = active;
        p_hs     = (m_state == 2) && (mh >= HA + HF) && (mh < HA + HF + HSW);
        p_vs     = (m_state == 2) && (mv >= VA + VF) && (mv < VA + VF + VSW);
        p_freq   = ((m_state == 0) && bus.en) || ((m_state == 2) && (mh == 0) && (mv == VA));
        if (bus.underflow_clr) begin
            e_uf  = 1'b0;
            e_cnt = 0;
        end else if (active && !vld) begin
            e_uf = 1'b1;
            if (e_cnt < 65535) e_cnt++;
        end
        case (m_state)
            0: if (bus.en) m_state = 1;
            1: begin
                if (!bus.en) m_state = 0;
                else if (vld) begin
                    m_state = 2; mh = 0; mv = 0;
                end
            end
            default: begin
                if (!bus.en) m_stop = 1'b1;
                if (mh == HT - 1) begin
                    mh = 0;
                    if (mv == VT - 1) begin
                        mv = 0;
                        if (m_stop) begin
                            m_state = 0;
                            m_stop  = 1'b0;
                        end
                    end else mv++;
                end else mh++;
            end
        endcase

        @(posedge clk);
        #1;
        cyc++;
        if (popped && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
    endtask

    task automatic run_to(input int v, input int h, input int max_c);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_c && !hit; i++) begin
            if (m_state == 2 && mv == v && mh == h) hit = 1'b1;
            else step();
        end
        if (!hit) hit = (m_state == 2 && mv == v && mh == h);
        chk("reach_pos", hit, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en            = 1'b0;
        bus.underflow_clr = 1'b0;
        bus.fifo_rd_vld   = 1'b0;
        bus.fifo_rd_data  = '0;
        #12;
        chk_reset("rst_");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Enable with an empty FIFO: one request, then parked in PRIME.
        bus.en = 1'b1;
        repeat (8) step();
        chk("prime_pops", pop_cnt, 0);
        chk("prime_freq", freq_cnt, 1);

        // Frame 1: 32 preloaded words, one per active pixel.
        for (int i = 0; i < 32; i++) fifo_q.push_back(24'(i));
        next_word = 24'd32;
        pop_cnt = 0;
        freq_cnt = 0;
        run_to(VT - 1, HT - 1, 120);
        chk("f1_pops", pop_cnt, 32);
        chk("f1_freq", freq_cnt, 1);

        // Frame 2: three-cycle gap at line 2, pixel 5.
        autofill = 1'b1;
        pop_cnt = 0;
        freq_cnt = 0;
        st_v = 2; st_h = 5; st_len = 3;
        step();
        run_to(VT - 1, HT - 1, 120);
        chk("f2_pops", pop_cnt, 29);
        chk("f2_uf", bus.underflow, 1);
        chk("f2_uf_cnt", bus.underflow_cnt, 3);
        chk("f2_freq", freq_cnt, 1);

        // Frame 3: clear lands on the same cycle as a starved pixel.
        st_v = 1; st_h = 3; st_len = 1;
        step();
        run_to(1, 3, 40);
        bus.underflow_clr = 1'b1;
        step();
        bus.underflow_clr = 1'b0;
        step();
        chk("clr_uf", bus.underflow, 0);
        chk("clr_uf_cnt", bus.underflow_cnt, 0);

        // Drop en mid-frame: lines 2..3 still drain, then idle.
        run_to(2, 0, 40);
        bus.en = 1'b0;
        pop_cnt = 0;
        run_to(VT - 1, HT - 1, 120);
        chk("drain_pops", pop_cnt, 16);
        step();
        pop_cnt = 0;
        repeat (20) step();
        chk("idle_pops", pop_cnt, 0);
        chk("idle_de", bus.vid_de, 0);

        // Restart, then async reset in the middle of an active line.
        st_v = 1; st_h = 1; st_len = 1;
        bus.en = 1'b1;
        run_to(1, 3, 60);
        chk("pre_rst_de", bus.vid_de, 1);
        chk("pre_rst_uf_cnt", bus.underflow_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("arst_");
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0; mh = 0; mv = 0; m_stop = 1'b0;
        p_active = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_freq = 1'b0;
        e_uf = 1'b0; e_cnt = 0;
        exp_q.delete();
        hs_len = 0; vs_len = 0; freq_cnt = 0;
        repeat (2) step();
        chk("post_rst_freq", freq_cnt, 1);
        run_to(0, 4, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_out_timing_gen.md
Name: hdmi_out_timing_gen

Overview:
- Video timing generator that sits directly downstream of the HDMI-out prefetch FIFO (24-bit RGB, first-word-fall-through, rd_en/rd_vld handshake).
- Generates HS/VS/DE raster timing and pops one FIFO word per active pixel.
- Drives registered RGB/sync to the HDMI encoder.
- Raises a frame request toward the upstream frame reader and reports FIFO underflow.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, HS width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, VS width
- V_BP, 20, vertical back porch
- HS_POL, 1, HS asserted level
- VS_POL, 1, VS asserted level
- FILL_RGB, 24'h000000, pixel substituted on underflow
- CNT_W, 12, h/v counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  start/continue video output
- fifo_rd_vld  in  1  FIFO head word valid
- fifo_rd_data  in  24  FIFO head word {R,G,B}
- fifo_rd_en  out  1  pop FIFO head this cycle
- vid_hs  out  1  horizontal sync
- vid_vs  out  1  vertical sync
- vid_de  out  1  data enable
- vid_rgb  out  24  pixel data
- frame_req  out  1  1-cycle pulse: upstream may start fetching next frame
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  clears underflow and underflow_cnt
- underflow_cnt  out  16  saturating count of substituted pixels
- pattern_sel  in  1  present only with TEST_PATTERN_EN

Behaviour:
- Totals: H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- Line layout: h_cnt 0..H_ACTIVE-1 active, then FP, SYNC, BP. Vertical uses the same order on v_cnt.
- Reset values: vid_hs=~HS_POL, vid_vs=~VS_POL, vid_de=0, vid_rgb=0, fifo_rd_en=0, frame_req=0, underflow=0, underflow_cnt=0. State=IDLE, h_cnt=v_cnt=0.
- States:
  - IDLE: counters held at 0, outputs at inactive levels. en=1 -> PRIME, with frame_req pulsed in the transition cycle.
  - PRIME: wait for fifo_rd_vld=1 -> RUN, starting at h=0, v=0. en=0 -> IDLE.
  - RUN: h_cnt increments each cycle and wraps at H_TOTAL-1. v_cnt increments on h wrap and wraps at V_TOTAL-1. If en=0 at any point, the current frame completes; at h=H_TOTAL-1, v=V_TOTAL-1 -> IDLE, otherwise wrap to a new frame.
- fifo_rd_en = RUN & active(h,v) & fifo_rd_vld. Combinational from registered counters; never asserted outside active region.
- Latency: outputs are registered, 1 cycle after the counter value that produced them.
  - vid_de = previous-cycle active.
  - vid_rgb = popped fifo_rd_data, or FILL_RGB if active & !fifo_rd_vld, or 0 when not active.
- Underflow: active & !fifo_rd_vld in RUN -> no pop, FILL_RGB output, underflow<=1, underflow_cnt+=1 saturating at 16'hFFFF.
  - underflow_clr has priority over a same-cycle increment: result is 0.
  - Raster never stalls; an underflowed pixel is lost, not delayed.
- frame_req: in RUN, a 1-cycle pulse at h=0, v=V_ACTIVE (start of vblank); also on IDLE->PRIME.
- Sync: hs asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs is analogous on v_cnt. vs changes at h=0.
- Async rst mid-frame: immediate return to reset values; FIFO contents are the owner's concern (reset shared).

Optional Feature:
- TEST_PATTERN_EN defined:
  - pattern_sel port exists.
  - pattern_sel=1 outputs 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_ACTIVE/8 wide.
  - fifo_rd_en forced 0, underflow counting suppressed, PRIME skips the fifo_rd_vld wait.
  - pattern_sel sampled only at h=0, v=0.
- Undefined: no pattern_sel port, no bar logic, FIFO always sourced.

Decomposition:
- Package hdmi_out_pkg:
  - state enum (IDLE, PRIME, RUN)
  - RGB width constant 24
  - colour-bar constant table
  - 720p default timing constants
- Sub-module: video_raster_cnt. Provides h/v counters, active, hs/vs raw decode and vblank-start strobe. Reused by the input side.

Test Plan:
- Small raster (H 8/2/2/2, V 4/1/1/1), FIFO preloaded with 32 incrementing words, en=1 -> 32 pops, vid_rgb 0..31 on DE, hs width 2, vs width 1, DE 1 cycle after counter active.
- FIFO empty at pixel 5 of line 2 for 3 cycles -> three FILL_RGB pixels, underflow=1, underflow_cnt=3, no pops during gap, raster timing unchanged.
- en=0 asserted mid-frame -> frame completes to v=V_TOTAL-1, h=H_TOTAL-1, then IDLE, outputs inactive, no further pops.
- en=1 with FIFO empty -> stays PRIME, no sync toggles. fifo_rd_vld rises -> RUN begins at h=0, v=0 next cycle.
- underflow_clr coincident with an underflow pixel -> underflow_cnt=0, underflow=0. frame_req pulses once per frame at v=V_ACTIVE, h=0.
- rst pulsed mid-active-line -> all outputs return to reset values same cycle; after release with en=1 -> frame_req pulse, PRIME.
